// File: rtl/ntt_pkg.sv
// Shared encodings for the NTT command sequencer: conf codes, op codes,
// done_flag bit positions, sequencer states and the conf lookup.
package ntt_pkg;

  localparam logic [2:0] CONF_IDLE      = 3'b000;
  localparam logic [2:0] CONF_NTT       = 3'b001;
  localparam logic [2:0] CONF_PWM       = 3'b010;
  localparam logic [2:0] CONF_INTT      = 3'b011;
  localparam logic [2:0] CONF_DONE_NTT  = 3'b100;
  localparam logic [2:0] CONF_DONE_INTT = 3'b101;

  localparam logic [1:0] OP_ILL  = 2'b00;
  localparam logic [1:0] OP_NTT  = 2'b01;
  localparam logic [1:0] OP_PWM  = 2'b10;
  localparam logic [1:0] OP_INTT = 2'b11;

  localparam int FLAG_NTT  = 0;
  localparam int FLAG_PWM  = 1;
  localparam int FLAG_INTT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // True when the index FSM reports completion of the operation in flight.
  function automatic logic flag_match(input logic [1:0] op, input logic [3:0] flags);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_NTT:  hit = flags[FLAG_NTT];
      OP_PWM:  hit = flags[FLAG_PWM];
      OP_INTT: hit = flags[FLAG_INTT];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [2:0] conf_for(input state_t st, input logic [1:0] op);
    logic [2:0] c;
    c = CONF_IDLE;
    case (st)
      S_RUN: begin
        case (op)
          OP_NTT:  c = CONF_NTT;
          OP_PWM:  c = CONF_PWM;
          OP_INTT: c = CONF_INTT;
          default: c = CONF_IDLE;
        endcase
      end
      S_DRAIN: c = (op == OP_INTT) ? CONF_DONE_INTT : CONF_DONE_NTT;
      default: c = CONF_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Host command and index-FSM status bundle of the NTT sequencer.
// master = host/index side, slave = sequencer.
interface ntt_seq_ctrl_if;
  logic       start;
  logic [1:0] op;
  logic       ready;
  logic [3:0] done_flag;
  logic [2:0] conf;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] cur_op;

  modport master (
    output start, op, done_flag,
    input  ready, conf, busy, done, err, cur_op
  );

  modport slave (
    input  start, op, done_flag,
    output ready, conf, busy, done, err, cur_op
  );
endinterface

// File: rtl/ntt_cmd_slot.sv
// One-deep pending command register; push and pop are never asserted together
// because push needs an empty slot and pop needs a full one.
module ntt_cmd_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] op_in,
  output logic [1:0] op_out,
  output logic       valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      op_out <= 2'b00;
    end else if (push) begin
      valid  <= 1'b1;
      op_out <= op_in;
    end else if (pop) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Sequences NTT/PWM/INTT commands onto the index FSM conf input: run code until
// the matching done_flag (or timeout), DRAIN_CYC drain cycles, one done cycle.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int DRAIN_CYC = 10,
  parameter int TIMEOUT   = 1023,
  parameter int CW        = 10
) (
  input  logic           clk,
  input  logic           rst,
  ntt_seq_ctrl_if.slave  bus
);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      cur_op_q, cur_op_n;
  logic [2:0]      conf_q, conf_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic            push, pop;
  logic            pend_v;
  logic [1:0]      pend_op;
  logic            accept, legal, hit;
  logic            unused_flag;

  assign accept      = bus.start & ~pend_v;
  assign legal       = (bus.op != OP_ILL);
  assign hit         = flag_match(cur_op_q, bus.done_flag);
  assign unused_flag = bus.done_flag[3];

  assign bus.ready  = ~pend_v;
  assign bus.busy   = (state != S_IDLE);
  assign bus.conf   = conf_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.cur_op = cur_op_q;

  ntt_cmd_slot u_slot (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .op_in  (bus.op),
    .op_out (pend_op),
    .valid  (pend_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_op_q <= 2'b00;
      conf_q   <= CONF_IDLE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_op_q <= cur_op_n;
      conf_q   <= conf_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_op_n = cur_op_q;
    err_n    = err_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (accept && !legal)
      err_n = 1'b1;

    case (state)
      S_IDLE: begin
        if (accept && legal) begin
          state_n  = S_RUN;
          cnt_n    = '0;
          cur_op_n = bus.op;
          err_n    = 1'b0;
        end
      end
      S_RUN: begin
        if (accept && legal)
          push = 1'b1;
        // A matching flag on the last allowed cycle still counts as success.
        if (hit) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (accept && legal)
          push = 1'b1;
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (pend_v) begin
          pop      = 1'b1;
          state_n  = S_RUN;
          cnt_n    = '0;
          cur_op_n = pend_op;
          err_n    = 1'b0;
        end else if (accept && legal) begin
          state_n  = S_RUN;
          cnt_n    = '0;
          cur_op_n = bus.op;
          err_n    = 1'b0;
        end else begin
          state_n  = S_IDLE;
          cur_op_n = 2'b00;
        end
      end
      default: state_n = S_IDLE;
    endcase

    conf_n = conf_for(state_n, cur_op_n);
    done_n = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: two instances (default and TIMEOUT=16) share stimulus
// and are compared every cycle against a command-level model, plus pinned cases.
module tb_ntt_seq_ctrl;

  localparam int DRAIN = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_s = 1'b0;
  logic [1:0] op_s = 2'b00;
  logic [3:0] flag_s = 4'b0000;

  int  cyc = 0;
  int  nchk = 0;
  int  nfail = 0;
  bit  chk_en = 1'b0;
  int  run_len = 640;
  bit  noise_en = 1'b0;

  ntt_seq_ctrl_if bus ();
  ntt_seq_ctrl_if bus_to ();

  assign bus.start        = start_s;
  assign bus.op           = op_s;
  assign bus.done_flag    = flag_s;
  assign bus_to.start     = start_s;
  assign bus_to.op        = op_s;
  assign bus_to.done_flag = flag_s;

  ntt_seq_ctrl u_dut (.clk(clk), .rst(rst), .bus(bus));
  ntt_seq_ctrl #(.DRAIN_CYC(DRAIN), .TIMEOUT(16), .CW(5)) u_dut_to (.clk(clk), .rst(rst), .bus(bus_to));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Command-level model: per instance, what is running, how long it has run,
  // how much drain remains, whether this is the done cycle, and the pending slot.
  int         tmo[2] = '{1023, 16};
  int         run_op[2] = '{0, 0};
  int         run_age[2] = '{0, 0};
  int         drain_left[2] = '{0, 0};
  bit         fin[2] = '{0, 0};
  bit         pv[2] = '{0, 0};
  int         pq[2] = '{0, 0};
  bit         err_m[2] = '{0, 0};
  int         cur[2] = '{0, 0};

  task automatic launch_m(input int i, input int o);
    run_op[i]  = o;
    run_age[i] = 0;
    cur[i]     = o;
    err_m[i]   = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        run_op[i] = 0; run_age[i] = 0; drain_left[i] = 0; fin[i] = 0;
        pv[i] = 0; pq[i] = 0; err_m[i] = 0; cur[i] = 0;
      end else begin
        bit acc, lg, hitf;
        acc = start_s && !pv[i];
        lg  = (op_s != 2'b00);
        if (acc && !lg) err_m[i] = 1'b1;
        if (fin[i]) begin
          fin[i] = 1'b0;
          if (pv[i]) begin pv[i] = 1'b0; launch_m(i, pq[i]); end
          else if (acc && lg) launch_m(i, int'(op_s));
          else cur[i] = 0;
        end else if (run_op[i] != 0) begin
          if (acc && lg) begin pv[i] = 1'b1; pq[i] = int'(op_s); end
          hitf = ((flag_s >> (run_op[i] - 1)) & 4'b0001) != 4'b0000;
          if (hitf || run_age[i] == tmo[i] - 1) begin
            if (!hitf) err_m[i] = 1'b1;
            run_op[i] = 0;
            drain_left[i] = DRAIN;
          end else begin
            run_age[i]++;
          end
        end else if (drain_left[i] > 0) begin
          if (acc && lg) begin pv[i] = 1'b1; pq[i] = int'(op_s); end
          drain_left[i]--;
          if (drain_left[i] == 0) fin[i] = 1'b1;
        end else if (acc && lg) begin
          launch_m(i, int'(op_s));
        end
      end
    end
  end

  function automatic int exp_conf(input int i);
    if (run_op[i] != 0) return run_op[i];
    if (drain_left[i] > 0) return (cur[i] == 3) ? 5 : 4;
    return 0;
  endfunction

  task automatic cmp(input int i, input logic [2:0] cf, input logic dn, input logic bs,
                     input logic rd, input logic er, input logic [1:0] co);
    string p;
    p = (i == 0) ? "dut" : "dut_to";
    chk({p, ".conf"},   int'(cf), exp_conf(i));
    chk({p, ".done"},   int'(dn), int'(fin[i]));
    chk({p, ".busy"},   int'(bs), int'(run_op[i] != 0 || drain_left[i] > 0 || fin[i]));
    chk({p, ".ready"},  int'(rd), int'(!pv[i]));
    chk({p, ".err"},    int'(er), int'(err_m[i]));
    chk({p, ".cur_op"}, int'(co), cur[i]);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst && chk_en) begin
      cmp(0, bus.conf, bus.done, bus.busy, bus.ready, bus.err, bus.cur_op);
      cmp(1, bus_to.conf, bus_to.done, bus_to.busy, bus_to.ready, bus_to.err, bus_to.cur_op);
    end
  end

  // Stand-in for the index FSM: raises the matching done bit on the run_len-th
  // run cycle, drives bit0 during DONE_INTT, optionally adds non-matching noise.
  int rc = 0;
  initial forever begin
    logic [3:0] f;
    int b;
    @(posedge clk);
    #1;
    f = 4'b0000;
    if (bus.conf >= 3'd1 && bus.conf <= 3'd3) begin
      rc++;
      if (rc == run_len) f = f | (4'b0001 << (int'(bus.conf) - 1));
    end else begin
      rc = 0;
    end
    if (bus.conf == 3'b101) f[0] = 1'b1;
    if (noise_en) begin
      b = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0 &&
          !(bus.conf >= 3'd1 && bus.conf <= 3'd3 && b == int'(bus.conf) - 1))
        f = f | (4'b0001 << b);
      if ($urandom_range(0, 3) == 0) f[3] = 1'b1;
    end
    flag_s = f;
  end

  task automatic at_neg(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic drv_at(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [1:0] o, output int c);
    start_s = 1'b1;
    op_s    = o;
    c       = cyc;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    op_s    = 2'b00;
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_conf", int'(bus.conf), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_cur_op", int'(bus.cur_op), 0);

    // Full-length NTT; the TIMEOUT=16 instance times out on the same command.
    run_len = 640;
    drv_at(cyc + 1);
    pulse(2'b01, c);
    at_neg(c + 1);   chk("ntt_conf_first", int'(bus.conf), 1);
    at_neg(c + 16);  chk("to_conf_last_run", int'(bus_to.conf), 1);
    at_neg(c + 17);  chk("to_conf_drain", int'(bus_to.conf), 4);
                     chk("to_err", int'(bus_to.err), 1);
    at_neg(c + 27);  chk("to_done", int'(bus_to.done), 1);
    at_neg(c + 640); chk("ntt_conf_640", int'(bus.conf), 1);
    at_neg(c + 641); chk("ntt_drain_641", int'(bus.conf), 4);
    at_neg(c + 650); chk("ntt_drain_650", int'(bus.conf), 4);
    at_neg(c + 651); chk("ntt_done_651", int'(bus.done), 1);
                     chk("ntt_conf_651", int'(bus.conf), 0);
    at_neg(c + 652); chk("ntt_busy_652", int'(bus.busy), 0);

    // Illegal op.
    drv_at(cyc + 1);
    pulse(2'b00, c);
    at_neg(c + 1);   chk("ill_busy", int'(bus.busy), 0);
                     chk("ill_conf", int'(bus.conf), 0);
                     chk("ill_err", int'(bus.err), 1);

    // NTT with PWM queued at run cycle 5.
    run_len = 20;
    drv_at(cyc + 1);
    pulse(2'b01, c);
    at_neg(c + 1);   chk("q_err_cleared", int'(bus.err), 0);
                     chk("to_err_cleared", int'(bus_to.err), 0);
    drv_at(c + 5);
    begin int c2; pulse(2'b10, c2); end
    at_neg(c + 6);   chk("q_ready_low", int'(bus.ready), 0);
    at_neg(c + 31);  chk("q_done", int'(bus.done), 1);
                     chk("q_ready_done", int'(bus.ready), 0);
    at_neg(c + 32);  chk("q_conf_pwm", int'(bus.conf), 2);
                     chk("q_ready_back", int'(bus.ready), 1);
    at_neg(c + 52);  chk("q_pwm_drain", int'(bus.conf), 4);
    at_neg(c + 62);  chk("q_pwm_done", int'(bus.done), 1);
    at_neg(c + 63);  chk("q_busy_end", int'(bus.busy), 0);

    // INTT: drain code 101 while the index FSM drives bit0.
    run_len = 30;
    drv_at(cyc + 1);
    pulse(2'b11, c);
    at_neg(c + 30);  chk("intt_conf_run", int'(bus.conf), 3);
    at_neg(c + 31);  chk("intt_drain_first", int'(bus.conf), 5);
    at_neg(c + 40);  chk("intt_drain_last", int'(bus.conf), 5);
    at_neg(c + 41);  chk("intt_done", int'(bus.done), 1);
                     chk("intt_err", int'(bus.err), 0);
    at_neg(c + 42);  chk("intt_idle", int'(bus.busy), 0);

    // Flag on the timeout cycle of the TIMEOUT=16 instance: flag wins.
    run_len = 16;
    drv_at(cyc + 1);
    pulse(2'b01, c);
    at_neg(c + 17);  chk("tie_to_conf", int'(bus_to.conf), 4);
                     chk("tie_to_err", int'(bus_to.err), 0);
    at_neg(c + 27);  chk("tie_to_done", int'(bus_to.done), 1);
    at_neg(c + 28);  chk("tie_to_idle", int'(bus_to.busy), 0);

    // Asynchronous reset at run cycle 100.
    run_len = 5000;
    drv_at(cyc + 1);
    pulse(2'b01, c);
    drv_at(c + 100);
    #2 rst = 1'b0;
    #1;
    chk("arst_conf", int'(bus.conf), 0);
    chk("arst_busy", int'(bus.busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    at_neg(cyc);     chk("arst_ready", int'(bus.ready), 1);
                     chk("arst_done", int'(bus.done), 0);
    at_neg(cyc + 5); chk("arst_busy_after", int'(bus.busy), 0);

    // Randomized traffic against the model.
    noise_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (n % 250 == 0) begin
        case ($urandom_range(0, 5))
          0:       run_len = 1;
          1:       run_len = 2;
          2:       run_len = 16;
          3:       run_len = 17;
          4:       run_len = 1100;
          default: run_len = $urandom_range(3, 60);
        endcase
      end
      start_s = ($urandom_range(0, 5) == 0);
      op_s    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    end
    start_s = 1'b0;
    op_s    = 2'b00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
